apb_fanout_bridge: RTL and testbench

//  Parametrised successor to the flat APB pass-through: one upstream APB completer port

---
 rtl/apb_pkg.sv | 19 +
 rtl/apb_slv_decode.sv | 18 +
 rtl/apb_fanout_bridge.sv | 89 ++++++++
 tb/tb_apb_fanout_bridge.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: shared types and decode helper for the APB fan-out bridge.
package apb_pkg;
  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} bridge_state_e;
  typedef struct packed {
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
    logic                  write;
  } apb_req_t;
  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
  } apb_rsp_t;
  // Whole field above the window; anything beyond the slave count is a miss.
  function automatic logic [63:0] idx_of(input logic [63:0] addr, input int sel_lsb);
    return addr >> sel_lsb;
  endfunction
endpackage

// File: rtl/apb_slv_decode.sv
// apb_slv_decode: combinational slave index and decode-miss from the address.
module apb_slv_decode
  import apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int N_SLV   = 4,
  parameter int SEL_LSB = 12,
  parameter int IDX_W   = 2
) (
  input  logic [ADDR_W-1:0] paddr,
  output logic [IDX_W-1:0]  idx,
  output logic              miss
);
  logic [63:0] field;
  assign field = idx_of(64'(paddr), SEL_LSB);
  assign idx   = field[IDX_W-1:0];
  assign miss  = field >= 64'(N_SLV);
endmodule

// File: rtl/apb_fanout_bridge.sv
// apb_fanout_bridge: one APB completer fanned out to N_SLV APB requesters
// through a registered IDLE/SETUP/ACCESS/DONE FSM with decode-miss and watchdog errors.
module apb_fanout_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int N_SLV   = 4,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inp_psel,
  input  logic                    inp_penable,
  input  logic                    inp_pwrite,
  input  logic [ADDR_W-1:0]       inp_paddr,
  input  logic [DATA_W-1:0]       inp_pwdata,
  output logic                    inp_pready,
  output logic [DATA_W-1:0]       inp_prdata,
  output logic                    inp_pslverr,
  output logic [N_SLV-1:0]        outp_psel,
  output logic                    outp_penable,
  output logic                    outp_pwrite,
  output logic [ADDR_W-1:0]       outp_paddr,
  output logic [DATA_W-1:0]       outp_pwdata,
  input  logic [N_SLV-1:0]        outp_pready,
  input  logic [N_SLV*DATA_W-1:0] outp_prdata,
  input  logic [N_SLV-1:0]        outp_pslverr
);
  localparam int IDX_W = N_SLV > 1 ? $clog2(N_SLV) : 1;
  bridge_state_e state, nxt;
  apb_req_t req;
  apb_rsp_t rsp;
  logic [IDX_W-1:0] idx_r, dec_idx;
  logic dec_miss, accept, sel_rdy, sel_err, timeout;
  logic [DATA_W-1:0] sel_rdata;
  logic [15:0] wd;
  apb_slv_decode #(.ADDR_W(ADDR_W), .N_SLV(N_SLV), .SEL_LSB(SEL_LSB), .IDX_W(IDX_W)) u_dec (
    .paddr(inp_paddr),
    .idx  (dec_idx),
    .miss (dec_miss)
  );
  assign accept    = state == IDLE && inp_psel && !inp_penable;
  assign sel_rdy   = outp_pready[idx_r];
  assign sel_err   = outp_pslverr[idx_r];
  assign sel_rdata = outp_prdata[idx_r*DATA_W +: DATA_W];
  // Fires on the TIMEOUT-th ACCESS cycle; ready in that cycle still wins.
  assign timeout   = wd == 16'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = accept ? (dec_miss ? DONE : SETUP) : IDLE;
      SETUP:   nxt = ACCESS;
      ACCESS:  nxt = (sel_rdy || timeout) ? DONE : ACCESS;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      req   <= '0;
      rsp   <= '0;
      idx_r <= '0;
      wd    <= '0;
    end else begin
      wd <= state == ACCESS ? wd + 16'd1 : '0;
      if (accept) begin
        req   <= '{addr: inp_paddr, wdata: inp_pwdata, write: inp_pwrite};
        idx_r <= dec_idx;
        rsp   <= '{rdata: '0, err: dec_miss};
      end else if (state == ACCESS && sel_rdy)
        rsp <= '{rdata: req.write ? '0 : sel_rdata, err: sel_err};
      else if (state == ACCESS && timeout)
        rsp <= '{rdata: '0, err: 1'b1};
    end
  always_comb begin
    outp_psel    = (state == SETUP || state == ACCESS) ? N_SLV'(1) << idx_r : '0;
    outp_penable = state == ACCESS;
    outp_pwrite  = req.write;
    outp_paddr   = req.addr;
    outp_pwdata  = req.wdata;
    inp_pready   = state == DONE;
    inp_prdata   = inp_pready ? rsp.rdata : '0;
    inp_pslverr  = inp_pready && rsp.err;
  end
endmodule

// File: tb/tb_apb_fanout_bridge.sv
// tb_apb_fanout_bridge: directed scoreboard bench for apb_fanout_bridge (TIMEOUT=8).
module tb_apb_fanout_bridge;
  logic clk = 0, rst = 1;
  logic psel = 0, penable = 0, pwrite = 0;
  logic [31:0] paddr = 0, pwdata = 0;
  logic inp_pready, inp_pslverr;
  logic [31:0] inp_prdata;
  logic [3:0] outp_psel, outp_pready, outp_pslverr;
  logic outp_penable, outp_pwrite;
  logic [31:0] outp_paddr, outp_pwdata;
  logic [127:0] outp_prdata;
  logic [3:0] hang = 0, extra_rdy = 0, err_val = 0;
  int wst[4];
  int cnt[4];
  logic [31:0] rd_val[4];
  logic [32:0] sb[$];
  int checks = 0, failures = 0, sel_viol = 0, gate_viol = 0;

  apb_fanout_bridge #(.N_SLV(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .inp_psel(psel), .inp_penable(penable), .inp_pwrite(pwrite),
    .inp_paddr(paddr), .inp_pwdata(pwdata),
    .inp_pready(inp_pready), .inp_prdata(inp_prdata), .inp_pslverr(inp_pslverr),
    .outp_psel(outp_psel), .outp_penable(outp_penable), .outp_pwrite(outp_pwrite),
    .outp_paddr(outp_paddr), .outp_pwdata(outp_pwdata),
    .outp_pready(outp_pready), .outp_prdata(outp_prdata), .outp_pslverr(outp_pslverr)
  );

  always #5 clk = ~clk;

  // Downstream slave models: ready after wst[k] wait states unless hung.
  always @(posedge clk)
    for (int k = 0; k < 4; k++)
      if (!outp_psel[k]) cnt[k] <= 0;
      else if (outp_penable && !outp_pready[k]) cnt[k] <= cnt[k] + 1;

  always_comb begin
    outp_pready  = '0;
    outp_prdata  = '0;
    outp_pslverr = '0;
    for (int k = 0; k < 4; k++) begin
      outp_pready[k] = (outp_psel[k] && outp_penable && !hang[k] && cnt[k] == wst[k]) || extra_rdy[k];
      outp_prdata[k*32 +: 32] = rd_val[k];
      outp_pslverr[k] = err_val[k];
    end
  end

  always @(negedge clk)
    if (!rst) begin
      if (!$onehot0(outp_psel)) sel_viol <= sel_viol + 1;
      if (!inp_pready && (inp_prdata != 0 || inp_pslverr)) gate_viol <= gate_viol + 1;
    end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input string tag, input logic [31:0] a, input logic w, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                      input logic [3:0] exp_sel, input int exp_sel_cyc);
    int cyc = 0, sel_cyc = 0, bad_sel = 0, bad_bus = 0;
    logic got = 0;
    logic [32:0] e;
    sb.push_back({exp_rd, exp_err});
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = w; paddr = a; pwdata = wd;
    while (!got && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (outp_psel != 0) begin
        sel_cyc++;
        if (outp_psel !== exp_sel) bad_sel++;
        if (outp_paddr !== a || outp_pwdata !== wd || outp_pwrite !== w) bad_bus++;
      end
      if (inp_pready) got = 1;
      else begin
        @(posedge clk); #1;
        penable = 1;
      end
    end
    e = sb.pop_front();
    chk({tag, "_done"}, 64'(got), 64'd1);
    chk({tag, "_rdata"}, 64'(inp_prdata), 64'(e[32:1]));
    chk({tag, "_err"}, 64'(inp_pslverr), 64'(e[0]));
    chk({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    chk({tag, "_selcyc"}, 64'(sel_cyc), 64'(exp_sel_cyc));
    chk({tag, "_selpat"}, 64'(bad_sel), 64'd0);
    chk({tag, "_bus"}, 64'(bad_bus), 64'd0);
    @(posedge clk); #1;
    psel = 0; penable = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_psel"}, 64'(outp_psel), 64'd0);
    chk({tag, "_penable"}, 64'(outp_penable), 64'd0);
    chk({tag, "_pwrite"}, 64'(outp_pwrite), 64'd0);
    chk({tag, "_paddr"}, 64'(outp_paddr), 64'd0);
    chk({tag, "_pwdata"}, 64'(outp_pwdata), 64'd0);
    chk({tag, "_pready"}, 64'(inp_pready), 64'd0);
    chk({tag, "_prdata"}, 64'(inp_prdata), 64'd0);
    chk({tag, "_pslverr"}, 64'(inp_pslverr), 64'd0);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      wst[k] = 0;
      rd_val[k] = 32'h0;
    end
    #1 chk_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 0;
    // 1: write to slave 1, immediately ready; read-data lines must not leak into a write
    rd_val[1] = 32'hFFFF_FFFF;
    xfer("wr_s1", 32'h0000_1004, 1, 32'hDEAD_BEEF, 32'h0, 0, 4, 4'b0010, 2);
    // 2: read slave 3 with 5 wait states
    rd_val[3] = 32'h1234_5678; wst[3] = 5;
    xfer("rd_s3", 32'h0000_3000, 0, 32'h0, 32'h1234_5678, 0, 9, 4'b1000, 7);
    // 3: decode miss
    xfer("miss", 32'h0000_7000, 0, 32'h0, 32'h0, 1, 2, 4'b0000, 0);
    // 4: watchdog timeout, then ready on the last allowed cycle
    rd_val[0] = 32'hAAAA_5555; hang[0] = 1;
    xfer("tmo", 32'h0000_0010, 0, 32'h0, 32'h0, 1, 11, 4'b0001, 9);
    hang[0] = 0; wst[0] = 7;
    xfer("tmo_edge", 32'h0000_0010, 0, 32'h0, 32'hAAAA_5555, 0, 11, 4'b0001, 9);
    // 5: slave error forwarded; unselected slaves' ready/err ignored
    rd_val[2] = 32'hCAFE_F00D; wst[2] = 2; err_val = 4'b1111; extra_rdy = 4'b1011;
    xfer("err_s2", 32'h0000_2008, 0, 32'h0, 32'hCAFE_F00D, 1, 6, 4'b0100, 4);
    wst[0] = 1; err_val = 4'b1110; extra_rdy = 4'b1110;
    xfer("noise_s0", 32'h0000_0020, 0, 32'h0, 32'hAAAA_5555, 0, 5, 4'b0001, 3);
    extra_rdy = 0; err_val = 0;
    // 6: asynchronous reset in ACCESS
    hang[0] = 1;
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = 1; paddr = 32'h0000_0040; pwdata = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    penable = 1;
    repeat (3) @(posedge clk);
    #3 chk("pre_rst_penable", 64'(outp_penable), 64'd1);
    rst = 1;
    #1 chk_zero("async_rst");
    psel = 0; penable = 0;
    @(posedge clk); #1;
    rst = 0; hang[0] = 0; wst[0] = 0; rd_val[0] = 32'h0BAD_C0DE;
    xfer("post_rst", 32'h0000_0044, 0, 32'h0, 32'h0BAD_C0DE, 0, 4, 4'b0001, 2);
    @(negedge clk);
    chk("onehot_psel", 64'(sel_viol), 64'd0);
    chk("idle_gating", 64'(gate_viol), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
